// File: rtl/rgmii_rx_decode_if.sv
// rgmii_rx_decode_if: GMII receive beat bus; rxd/dv/er are qualified by valid.
//   master: drives gmii_rxd[7:0], gmii_rx_dv, gmii_rx_er, gmii_rx_valid
//   slave:  observes the same signals
interface rgmii_rx_decode_if;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic       gmii_rx_valid;
   modport master (output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid);
   modport slave  (input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid);
endinterface

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: turns RGMII DDR captures into GMII beats and latches in-band link status.
//   q1/q2: rising/falling captures {rx_ctl, rxd[3:0]}; speed: 00=10M, 01=100M, 1x=1000M
//   gmii: registered beat bus; link_*: in-band status; nibble_err: truncated 10/100 byte pulse
module rgmii_rx_decode #(
   parameter int ENABLE_INBAND = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        q1,
   input  logic [4:0]        q2,
   input  logic [1:0]        speed,
   rgmii_rx_decode_if.master gmii,
   output logic              link_up,
   output logic [1:0]        link_speed,
   output logic              link_full_duplex,
   output logic              nibble_err
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t     state_q, state_d;
   logic [3:0] nib_q, nib_d;
   logic [7:0] rxd_q, rxd_d;
   logic [1:0] speed_q, speed_d, lspd_q, lspd_d;
   logic       nib_er_q, nib_er_d, tail_q, tail_d, armed_q, armed_d;
   logic       dv_q, dv_d, er_q, er_d, valid_q, valid_d, nerr_q, nerr_d;
   logic       up_q, up_d, fd_q, fd_d;
   logic       dv, er, upd;
   // tail_q: second beat owed after a truncated byte; armed_q: dv seen low since reset
   always_comb begin
      dv = q1[4];
      er = q1[4] ^ q2[4];
      upd = ENABLE_INBAND != 0 && !q1[4] && !q2[4] && q1[3:0] == q2[3:0];
      up_d = upd ? q1[0] : up_q;
      lspd_d = upd ? q1[2:1] : lspd_q;
      fd_d = upd ? q1[3] : fd_q;
      speed_d = speed;
      armed_d = armed_q | ~dv;
      state_d = state_q;
      nib_d = nib_q;
      nib_er_d = nib_er_q;
      tail_d = 1'b0;
      nerr_d = 1'b0;
      valid_d = 1'b0;
      rxd_d = rxd_q;
      dv_d = dv_q;
      er_d = er_q;
      if (speed_q[1]) begin
         state_d = IDLE;
         valid_d = 1'b1;
         rxd_d = {q2[3:0], q1[3:0]};
         dv_d = dv;
         er_d = er;
      end else if (speed != speed_q) begin
         state_d = IDLE;
      end else begin
         if (tail_q) begin
            valid_d = 1'b1;
            rxd_d = 8'h00;
            dv_d = 1'b0;
            er_d = 1'b0;
         end
         case (state_q)
            IDLE: if (dv && armed_q) begin
               state_d = HIGH;
               nib_d = q1[3:0];
               nib_er_d = er;
            end
            HIGH: begin
               valid_d = 1'b1;
               dv_d = 1'b1;
               rxd_d = {dv ? q1[3:0] : 4'h0, nib_q};
               er_d = dv ? nib_er_q | er : 1'b1;
               nerr_d = ~dv;
               tail_d = ~dv;
               state_d = dv ? LOW : IDLE;
            end
            LOW: if (dv) begin
               state_d = HIGH;
               nib_d = q1[3:0];
               nib_er_d = er;
            end else begin
               valid_d = 1'b1;
               rxd_d = 8'h00;
               dv_d = 1'b0;
               er_d = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         nib_q <= '0;
         nib_er_q <= 1'b0;
         tail_q <= 1'b0;
         armed_q <= 1'b0;
         speed_q <= '0;
         rxd_q <= '0;
         dv_q <= 1'b0;
         er_q <= 1'b0;
         valid_q <= 1'b0;
         nerr_q <= 1'b0;
         up_q <= 1'b0;
         lspd_q <= '0;
         fd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         nib_q <= nib_d;
         nib_er_q <= nib_er_d;
         tail_q <= tail_d;
         armed_q <= armed_d;
         speed_q <= speed_d;
         rxd_q <= rxd_d;
         dv_q <= dv_d;
         er_q <= er_d;
         valid_q <= valid_d;
         nerr_q <= nerr_d;
         up_q <= up_d;
         lspd_q <= lspd_d;
         fd_q <= fd_d;
      end
   end
   assign gmii.gmii_rxd = rxd_q;
   assign gmii.gmii_rx_dv = dv_q;
   assign gmii.gmii_rx_er = er_q;
   assign gmii.gmii_rx_valid = valid_q;
   assign link_up = up_q;
   assign link_speed = lspd_q;
   assign link_full_duplex = fd_q;
   assign nibble_err = nerr_q;
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed plus randomized checks of rgmii_rx_decode against a frame-level model.
module tb_rgmii_rx_decode;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] q1 = '0, q2 = '0;
   logic [1:0] speed = 2'b01;
   logic       link_up, link_full_duplex, nibble_err;
   logic [1:0] link_speed;
   int         tests = 0, fails = 0, nerr_seen = 0;
   logic [9:0] obs[$];
   logic [3:0] fn[16];
   logic       fe[16];
   logic [4:0] pa, pb;
   bit         have = 0;
   rgmii_rx_decode_if gmii ();
   rgmii_rx_decode #(.ENABLE_INBAND(1)) dut (
      .clk(clk), .rst(rst), .q1(q1), .q2(q2), .speed(speed), .gmii(gmii),
      .link_up(link_up), .link_speed(link_speed), .link_full_duplex(link_full_duplex),
      .nibble_err(nibble_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (!rst) begin
      if (gmii.gmii_rx_valid) obs.push_back({gmii.gmii_rx_dv, gmii.gmii_rx_er, gmii.gmii_rxd});
      if (nibble_err) nerr_seen++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      q1 = a;
      q2 = b;
   endtask
   task automatic idle(input int n);
      repeat (n) cyc(5'h00, 5'h00);
   endtask
   task automatic chk_link(input string tag, input logic up, input logic [1:0] spd, input logic fd);
      chk({tag, " up"}, 32'(link_up), 32'(up));
      chk({tag, " speed"}, 32'(link_speed), 32'(spd));
      chk({tag, " fd"}, 32'(link_full_duplex), 32'(fd));
   endtask
   // 10/100 model: nibbles pair up low-first; an odd tail becomes {0,nib} with er, then an idle beat
   task automatic frame(input int n, input string tag);
      logic [9:0] exp[$];
      int ob, nb;
      idle(3);
      ob = obs.size();
      nb = nerr_seen;
      for (int i = 0; i < n; i++) cyc({1'b1, fn[i]}, {~fe[i], fn[i]});
      idle(4);
      for (int i = 0; i + 1 < n; i += 2) exp.push_back({1'b1, fe[i] | fe[i+1], fn[i+1], fn[i]});
      if (n % 2 == 1) exp.push_back({2'b11, 4'h0, fn[n-1]});
      if (n > 0) exp.push_back(10'h000);
      chk({tag, " count"}, 32'(obs.size() - ob), 32'(exp.size()));
      foreach (exp[i]) if (ob + i < obs.size()) chk({tag, " beat"}, 32'(obs[ob+i]), 32'(exp[i]));
      chk({tag, " nerr"}, 32'(nerr_seen - nb), 32'(n % 2));
   endtask
   // 1000M model: each cycle's inputs reappear one cycle later as a full byte
   task automatic gstep(input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      if (have) begin
         chk("g valid", 32'(gmii.gmii_rx_valid), 32'd1);
         chk("g rxd", 32'(gmii.gmii_rxd), 32'({pb[3:0], pa[3:0]}));
         chk("g dv", 32'(gmii.gmii_rx_dv), 32'(pa[4]));
         chk("g er", 32'(gmii.gmii_rx_er), 32'(pa[4] ^ pb[4]));
         chk("g nerr", 32'(nibble_err), 32'd0);
      end
      q1 = a;
      q2 = b;
      pa = a;
      pb = b;
      have = 1;
   endtask
   initial begin
      int ob, nb, n;
      repeat (2) @(negedge clk);
      chk("rst rxd", 32'(gmii.gmii_rxd), 32'd0);
      chk("rst valid", 32'(gmii.gmii_rx_valid), 32'd0);
      chk("rst dv", 32'(gmii.gmii_rx_dv), 32'd0);
      chk("rst er", 32'(gmii.gmii_rx_er), 32'd0);
      chk("rst nerr", 32'(nibble_err), 32'd0);
      chk_link("rst", 1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      speed = 2'b01;
      fn[0] = 4'h5; fn[1] = 4'h5; fn[2] = 4'hD; fn[3] = 4'h5;
      for (int i = 0; i < 16; i++) fe[i] = 1'b0;
      frame(4, "100M 55 5D");
      fn[0] = 4'hA; fn[1] = 4'hB; fn[2] = 4'hC;
      frame(3, "100M trunc");
      speed = 2'b00;
      fn[0] = 4'h3; fn[1] = 4'h9; fe[0] = 1'b1;
      frame(2, "10M er");
      speed = 2'b01;
      idle(3);
      cyc(5'h0D, 5'h0D);
      cyc(5'h02, 5'h04);
      chk_link("inband set", 1'b1, 2'b10, 1'b1);
      cyc(5'h0D, 5'h0C);
      chk_link("inband hold mismatch", 1'b1, 2'b10, 1'b1);
      cyc(5'h02, 5'h02);
      chk_link("inband hold nib", 1'b1, 2'b10, 1'b1);
      cyc(5'h00, 5'h00);
      chk_link("inband update", 1'b0, 2'b01, 1'b0);
      idle(2);
      ob = obs.size();
      nb = nerr_seen;
      cyc(5'h1A, 5'h1A);
      @(negedge clk);
      speed = 2'b00;
      q1 = 5'h1B;
      q2 = 5'h1B;
      idle(4);
      chk("spdchg beats", 32'(obs.size() - ob), 32'd0);
      chk("spdchg nerr", 32'(nerr_seen - nb), 32'd0);
      speed = 2'b01;
      idle(3);
      cyc(5'h0D, 5'h0D);
      cyc(5'h15, 5'h15);
      cyc(5'h1A, 5'h1A);
      cyc(5'h13, 5'h13);
      chk("pre rst rxd", 32'(gmii.gmii_rxd), 32'hA5);
      chk("pre rst valid", 32'(gmii.gmii_rx_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async rst rxd", 32'(gmii.gmii_rxd), 32'd0);
      chk("async rst valid", 32'(gmii.gmii_rx_valid), 32'd0);
      chk("async rst dv", 32'(gmii.gmii_rx_dv), 32'd0);
      chk_link("async rst", 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      ob = obs.size();
      nb = nerr_seen;
      rst = 1'b0;
      repeat (3) cyc(5'h17, 5'h17);
      idle(4);
      chk("post rst partial beats", 32'(obs.size() - ob), 32'd0);
      chk("post rst partial nerr", 32'(nerr_seen - nb), 32'd0);
      for (int r = 0; r < 12; r++) begin
         speed = 2'($urandom_range(0, 1));
         n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) begin
            fn[i] = 4'($urandom);
            fe[i] = ($urandom_range(0, 7) == 0);
         end
         frame(n, "rand 10/100");
      end
      speed = 2'b10;
      have = 0;
      idle(3);
      repeat (8) gstep(5'h15, 5'h15);
      gstep(5'h00, 5'h00);
      gstep(5'h00, 5'h00);
      gstep(5'h0D, 5'h0D);
      gstep(5'h03, 5'h13);
      gstep(5'h00, 5'h00);
      chk_link("g false carrier", 1'b1, 2'b10, 1'b1);
      repeat (40) gstep(5'($urandom), 5'($urandom));
      gstep(5'h00, 5'h00);
      have = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rgmii_rx_decode.md
RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

Interface
REQ-001 SHALL have parameter ENABLE_INBAND, default 1, which enables decoding of RGMII in-band link status.
REQ-002 SHALL have port clk, input, 1 bit: RGMII receive clock, the same clock that drives the input DDR capture stage.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port q1, input, 5 bits: rising-edge capture {rx_ctl, rxd[3:0]}.
REQ-005 SHALL have port q2, input, 5 bits: falling-edge capture {rx_ctl, rxd[3:0]}, aligned to q1.
REQ-006 SHALL have port speed, input, 2 bits: 00 = 10M, 01 = 100M, 10 or 11 = 1000M.
REQ-007 SHALL have port gmii_rxd, output, 8 bits: received byte.
REQ-008 SHALL have ports gmii_rx_dv and gmii_rx_er, outputs, 1 bit each: data valid and error.
REQ-009 SHALL have port gmii_rx_valid, output, 1 bit: beat strobe; gmii_rxd, gmii_rx_dv and gmii_rx_er are meaningful only while it is high.
REQ-010 SHALL have ports link_up (1 bit), link_speed (2 bits) and link_full_duplex (1 bit), outputs: latched in-band status.
REQ-011 SHALL have port nibble_err, output, 1 bit: one-cycle pulse on a truncated byte in 10/100 mode.

Function
REQ-012 SHALL compute dv = q1[4] and er = q1[4] XOR q2[4] every cycle.
REQ-013 In 1000M mode, SHALL drive the following one cycle after q1/q2 (latency 1): gmii_rx_valid = 1 every cycle, gmii_rxd = {q2[3:0], q1[3:0]}, gmii_rx_dv = dv, gmii_rx_er = er.
REQ-014 In 1000M mode, SHALL hold the nibble FSM in IDLE and keep nibble_err at 0.
REQ-015 In 10/100 mode, SHALL use only q1[3:0] as data, one nibble per cycle, low nibble first.
REQ-016 The 10/100 FSM SHALL have states IDLE, HIGH (low nibble held, waiting for the high nibble) and LOW (byte complete, waiting for the next low nibble).
REQ-017 IDLE with dv=1 SHALL store the nibble and its er value, then go to HIGH; IDLE with dv=0 SHALL produce no output beat.
REQ-018 HIGH with dv=1 SHALL emit one beat on the next cycle (rxd = {q1[3:0], held nibble}, dv=1, er = held er OR current er), then go to LOW.
REQ-019 LOW with dv=1 SHALL store the nibble and go to HIGH.
REQ-020 LOW with dv=0 SHALL emit one beat (rxd=0, dv=0, er=0) and go to IDLE.
REQ-021 HIGH with dv=0 (odd nibble count) SHALL emit one beat (rxd = {4'h0, held nibble}, dv=1, er=1) and pulse nibble_err for one cycle.
REQ-022 That same HIGH-with-dv=0 case SHALL emit a second beat on the following cycle (dv=0, er=0), then go to IDLE.
REQ-023 In 10/100 mode, gmii_rx_valid SHALL be 0 on every cycle not named in REQ-018, REQ-020, REQ-021 and REQ-022.
REQ-024 A change of speed in any non-IDLE state SHALL force IDLE on the next cycle and discard any held nibble, with no beat emitted and no nibble_err pulse.
REQ-025 The new speed SHALL take effect in the cycle following the change.
REQ-026 With ENABLE_INBAND=1, when q1[4]=0, q2[4]=0 and q1[3:0]=q2[3:0], SHALL register link_up=q1[0], link_speed=q1[2:1] and link_full_duplex=q1[3], with latency 1.
REQ-027 Under any other input combination, SHALL hold the link status outputs.
REQ-028 With ENABLE_INBAND=0, SHALL hold all link status outputs at 0.
REQ-029 When dv=0 and er=1 (carrier extend / false carrier) in 1000M mode, SHALL pass the beat through unchanged and SHALL NOT update link status.
REQ-030 Every output SHALL be driven from a register; there SHALL be no combinational path from input to output.

Reset
REQ-031 On rst high, SHALL immediately clear all outputs to 0 (including link_speed = 2'b00) and set the FSM to IDLE.
REQ-032 Asserting rst mid-frame SHALL discard any held nibble.
REQ-033 After rst falls, SHALL resume decoding on the first rising clk edge.
REQ-034 Decoding after reset SHALL start from IDLE; any partial frame in progress SHALL be ignored until dv is next observed low-then-high.

Verification
REQ-035 1000M: q1={1,5}, q2={1,5} for 8 cycles, then ctl=0 -> 8 beats of rxd=0x55, dv=1, er=0, each 1 cycle later; the next beat has dv=0.
REQ-036 100M: nibbles 5,5,D,5 with dv=1, then dv=0 -> beats 0x55 and 0x5D, each with dv=1; then one beat with dv=0; valid high exactly 3 cycles in total.
REQ-037 100M truncated frame: nibbles A,B,C with dv=1, then dv=0 -> beats 0xBA (dv=1) and 0x0C (dv=1, er=1) with nibble_err pulsed, then a dv=0 beat.
REQ-038 Error mid-byte at 10M: low nibble with ctl q1=1/q2=0, high nibble clean -> that byte has er=1.
REQ-039 In-band status: idle with q1=q2={0,0xD} -> link_up=1, link_speed=2'b10, link_full_duplex=1; q2={0,0xC} with q1 unchanged -> status held.
REQ-040 Speed change: 100M frame in state HIGH, speed switched to 10 -> no beat, no nibble_err; rst asserted mid-frame -> all outputs 0 asynchronously.
